// File: rtl/ov7670_emulator.sv
// OV7670-style camera source: vsync/href/pclk timing with a YUV422 ramp pattern.
// Optional OV_EMU_VSYNC_GLITCH_EN adds a short false vsync pulse before every frame.
module ov7670_emulator #(
  parameter int COLS          = 640,
  parameter int ROWS          = 480,
  parameter int HBLANK        = 288,
  parameter int VSYNC_LINES   = 3,
  parameter int VBP_LINES     = 17,
  parameter int VFP_LINES     = 10,
  parameter int GLITCH_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] luma_base,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int T_LINE   = 2 * COLS + HBLANK;
  localparam int CNT_LEN  = (T_LINE > GLITCH_CYCLES) ? T_LINE : GLITCH_CYCLES;
  localparam int CNT_W    = $clog2(CNT_LEN + 1);
  localparam int LINE_MAX = (VSYNC_LINES > VBP_LINES)
                            ? ((VSYNC_LINES > VFP_LINES) ? VSYNC_LINES : VFP_LINES)
                            : ((VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES);
  localparam int LINE_W   = $clog2(LINE_MAX + 1);
  localparam int ROW_W    = $clog2(ROWS + 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_VSYNC      = 3'd1;
  localparam logic [2:0] S_VBP        = 3'd2;
  localparam logic [2:0] S_ACTIVE     = 3'd3;
  localparam logic [2:0] S_HBLANK     = 3'd4;
  localparam logic [2:0] S_VFP        = 3'd5;
`ifdef OV_EMU_VSYNC_GLITCH_EN
  localparam logic [2:0] S_GLITCH     = 3'd6;
  localparam logic [2:0] S_GLITCH_GAP = 3'd7;
  localparam logic [2:0] S_START      = S_GLITCH;
`else
  localparam logic [2:0] S_START      = S_VSYNC;
`endif

  logic [2:0]        state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [LINE_W-1:0] line, nxt_line;
  logic [ROW_W-1:0]  row, nxt_row;
  logic [7:0]        luma_q;
  logic              start, line_end, nxt_done, nxt_vsync;
  logic [7:0]        nxt_y;

  assign line_end = (cnt == CNT_W'(T_LINE - 1));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    nxt_line  = line;
    nxt_row   = row;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        start   = en;
      end
      S_VSYNC, S_VBP, S_VFP: begin
        if (line_end) begin
          nxt_cnt = '0;
          if ((state == S_VSYNC && line == LINE_W'(VSYNC_LINES - 1)) ||
              (state == S_VBP   && line == LINE_W'(VBP_LINES - 1))   ||
              (state == S_VFP   && line == LINE_W'(VFP_LINES - 1))) begin
            nxt_line = '0;
            if (state == S_VSYNC)      nxt_state = S_VBP;
            else if (state == S_VBP)   nxt_state = S_ACTIVE;
            else if (en)               start     = 1'b1;
            else                       nxt_state = S_IDLE;
          end else begin
            nxt_line = line + LINE_W'(1);
          end
        end
      end
      S_ACTIVE: begin
        if (cnt == CNT_W'(2 * COLS - 1)) begin
          nxt_cnt   = '0;
          nxt_state = S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt == CNT_W'(HBLANK - 1)) begin
          nxt_cnt = '0;
          if (row == ROW_W'(ROWS - 1)) begin
            nxt_row   = '0;
            nxt_state = S_VFP;
          end else begin
            nxt_row   = row + ROW_W'(1);
            nxt_state = S_ACTIVE;
          end
        end
      end
`ifdef OV_EMU_VSYNC_GLITCH_EN
      S_GLITCH: begin
        if (cnt == CNT_W'(GLITCH_CYCLES - 1)) begin
          nxt_cnt   = '0;
          nxt_state = S_GLITCH_GAP;
        end
      end
      S_GLITCH_GAP: begin
        if (cnt == CNT_W'(GLITCH_CYCLES - 1)) begin
          nxt_cnt   = '0;
          nxt_state = S_VSYNC;
        end
      end
`endif
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
    if (start) begin
      nxt_state = S_START;
      nxt_cnt   = '0;
      nxt_line  = '0;
      nxt_row   = '0;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state.
`ifdef OV_EMU_VSYNC_GLITCH_EN
  assign nxt_vsync = (nxt_state == S_VSYNC) || (nxt_state == S_GLITCH);
`else
  assign nxt_vsync = (nxt_state == S_VSYNC);
`endif
  assign nxt_done = (nxt_state == S_VFP) && (nxt_cnt == CNT_W'(T_LINE - 1)) &&
                    (nxt_line == LINE_W'(VFP_LINES - 1));
  assign nxt_y    = 8'(32'(nxt_cnt >> 1) + 32'(nxt_row) + 32'(luma_q));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      line        <= '0;
      row         <= '0;
      luma_q      <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      line       <= nxt_line;
      row        <= nxt_row;
      vsync      <= nxt_vsync;
      href       <= (nxt_state == S_ACTIVE);
      frame_done <= nxt_done;
      if (start) luma_q <= luma_base;
      if (nxt_state == S_ACTIVE) data <= nxt_cnt[0] ? 8'h80 : nxt_y;
      else                       data <= 8'h00;
      if (nxt_done) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
